// File: rtl/matrix_display_reader_pkg.sv
// Shared definitions for the matrix display reader.
//   MAX_MATRICES / RESP_TIMEOUT : default slot count and response timeout
//   ASCII constants             : characters used in the output stream
//   state_t                     : reader FSM state encoding
package matrix_display_reader_pkg;

    localparam int MAX_MATRICES = 10;
    localparam int RESP_TIMEOUT = 15;

    localparam logic [7:0] MINUS = 8'h2D;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] LC_X  = 8'h78;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_META,
        S_RD,
        S_WAIT_DATA,
        S_EMIT,
        S_FIN
    } state_t;

endpackage

// File: rtl/matrix_display_reader_if.sv
// Storage display port plus the outgoing byte stream.
//   master : reader side (drives requests and tx bytes)
//   slave  : storage / transmitter side
interface matrix_display_reader_if;
    logic       stor_start_disp;
    logic [3:0] stor_matrix_id;
    logic       stor_read_en;
    logic [7:0] stor_data;
    logic       stor_data_valid;
    logic       stor_meta_valid;
    logic       stor_error;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output stor_start_disp, stor_matrix_id, stor_read_en, tx_data, tx_valid,
        input  stor_data, stor_data_valid, stor_meta_valid, stor_error, tx_ready
    );

    modport slave (
        input  stor_start_disp, stor_matrix_id, stor_read_en, tx_data, tx_valid,
        output stor_data, stor_data_valid, stor_meta_valid, stor_error, tx_ready
    );
endinterface

// File: rtl/matrix_display_reader_elem_to_ascii.sv
// Combinational split of a signed 8-bit element into decimal digits.
//   value    in  : two's complement element
//   neg      out : element is negative
//   hundreds/tens/units out : binary digit values 0..9 of |value|
//   ndig     out : number of significant digits, 1..3
module elem_to_ascii (
    input  logic [7:0] value,
    output logic       neg,
    output logic [7:0] hundreds,
    output logic [7:0] tens,
    output logic [7:0] units,
    output logic [1:0] ndig
);
    logic [7:0] mag;

    always_comb begin
        neg = value[7];
        // 8-bit unsigned magnitude, so -128 becomes 128
        mag = value[7] ? (~value + 8'd1) : value;
        hundreds = mag / 8'd100;
        tens     = (mag / 8'd10) % 8'd10;
        units    = mag % 8'd10;
        if (mag >= 8'd100)     ndig = 2'd3;
        else if (mag >= 8'd10) ndig = 2'd2;
        else                   ndig = 2'd1;
    end
endmodule

// File: rtl/matrix_display_reader.sv
// Reads one stored matrix through the storage display port and streams it as
// ASCII decimal text on a valid/ready byte interface.
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, disp_id         : request to display matrix disp_id
//   list_m_flat/list_n_flat: per-slot row/column counts, 3 bits per slot
//   busy, done, err        : operation status
//   bus (master)           : storage request/read port and tx byte stream
// Optional build macro MATRIX_DISP_HEADER_EN prefixes the stream with "<id>:<m>x<n>\r\n".
//
// state       | meaning
// S_IDLE      | wait for start
// S_REQ       | one-cycle display request to storage
// S_WAIT_META | wait for storage to accept/reject, with timeout
// S_RD        | one-cycle element read strobe
// S_WAIT_DATA | wait for element data, with timeout
// S_EMIT      | send buffered characters (header or element)
// S_FIN       | done pulse, err if failed
module matrix_display_reader #(
    parameter int MAX_MATRICES = matrix_display_reader_pkg::MAX_MATRICES,
    parameter int RESP_TIMEOUT = matrix_display_reader_pkg::RESP_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                disp_id,
    input  logic [3*MAX_MATRICES-1:0] list_m_flat,
    input  logic [3*MAX_MATRICES-1:0] list_n_flat,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    matrix_display_reader_if.master   bus
);
    import matrix_display_reader_pkg::*;

    localparam int            TW       = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(RESP_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [3:0]    id_q;
    logic [2:0]    m_q, n_q, row_q, col_q;
    logic [TW-1:0] tmo_q;
    logic          err_q, hdr_q;
    logic [7:0]    seq_q [8];
    logic [2:0]    idx_q, last_q;

    logic [2:0]    m_sel, n_sel, p, elem_last;
    logic          id_ok, last_col, last_elem, tmo_zero;
    logic [7:0]    elem_seq [8];
    logic          e_neg;
    logic [7:0]    e_h, e_t, e_u;
    logic [1:0]    e_nd;

    elem_to_ascii u_e2a (
        .value    (bus.stor_data),
        .neg      (e_neg),
        .hundreds (e_h),
        .tens     (e_t),
        .units    (e_u),
        .ndig     (e_nd)
    );

    always_comb begin
        m_sel = 3'd0;
        n_sel = 3'd0;
        for (int k = 0; k < MAX_MATRICES; k++) begin
            if ({28'd0, disp_id} == 32'(k)) begin
                m_sel = list_m_flat[3*k +: 3];
                n_sel = list_n_flat[3*k +: 3];
            end
        end
    end

    assign id_ok     = {28'd0, disp_id} < 32'(MAX_MATRICES);
    assign last_col  = ({1'b0, col_q} + 4'd1) >= {1'b0, n_q};
    assign last_elem = last_col && (({1'b0, row_q} + 4'd1) >= {1'b0, m_q});
    assign tmo_zero  = (tmo_q == '0);

    // Character sequence for the element arriving this cycle
    always_comb begin
        for (int k = 0; k < 8; k++) elem_seq[k] = 8'h00;
        p         = 3'd0;
        elem_last = 3'd0;
        if (e_neg) begin
            elem_seq[p] = MINUS;
            p = p + 3'd1;
        end
        if (e_nd == 2'd3) begin
            elem_seq[p] = ZERO + e_h;
            p = p + 3'd1;
        end
        if (e_nd >= 2'd2) begin
            elem_seq[p] = ZERO + e_t;
            p = p + 3'd1;
        end
        elem_seq[p] = ZERO + e_u;
        p = p + 3'd1;
        if (!last_col) begin
            elem_seq[p] = SPACE;
            elem_last   = p;
        end else begin
            elem_seq[p]        = CR;
            elem_seq[p + 3'd1] = LF;
            elem_last          = p + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start) state_d = id_ok ? S_REQ : S_FIN;
            S_REQ:       state_d = S_WAIT_META;
            S_WAIT_META: begin
                if (bus.stor_error)           state_d = S_FIN;
`ifdef MATRIX_DISP_HEADER_EN
                else if (bus.stor_meta_valid) state_d = S_EMIT;
`else
                else if (bus.stor_meta_valid) state_d = S_RD;
`endif
                else if (tmo_zero)            state_d = S_FIN;
            end
            S_RD:        state_d = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (bus.stor_data_valid) state_d = S_EMIT;
                else if (tmo_zero)       state_d = S_FIN;
            end
            S_EMIT: begin
                if (bus.tx_ready && idx_q == last_q)
                    state_d = (hdr_q || !last_elem) ? S_RD : S_FIN;
            end
            S_FIN:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q   <= 4'd0;
            m_q    <= 3'd0;
            n_q    <= 3'd0;
            row_q  <= 3'd0;
            col_q  <= 3'd0;
            tmo_q  <= '0;
            err_q  <= 1'b0;
            hdr_q  <= 1'b0;
            idx_q  <= 3'd0;
            last_q <= 3'd0;
            for (int k = 0; k < 8; k++) seq_q[k] <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    err_q <= !id_ok;
                    row_q <= 3'd0;
                    col_q <= 3'd0;
                    hdr_q <= 1'b0;
                    if (id_ok) begin
                        id_q <= disp_id;
                        m_q  <= m_sel;
                        n_q  <= n_sel;
                    end
                end
                S_REQ, S_RD: tmo_q <= TMO_LOAD;
                S_WAIT_META: begin
                    if (!tmo_zero) tmo_q <= tmo_q - 1'b1;
                    if (bus.stor_error || (!bus.stor_meta_valid && tmo_zero)) err_q <= 1'b1;
`ifdef MATRIX_DISP_HEADER_EN
                    if (!bus.stor_error && bus.stor_meta_valid) begin
                        seq_q[0] <= ZERO + {4'd0, id_q};
                        seq_q[1] <= COLON;
                        seq_q[2] <= ZERO + {5'd0, m_q};
                        seq_q[3] <= LC_X;
                        seq_q[4] <= ZERO + {5'd0, n_q};
                        seq_q[5] <= CR;
                        seq_q[6] <= LF;
                        idx_q    <= 3'd0;
                        last_q   <= 3'd6;
                        hdr_q    <= 1'b1;
                    end
`endif
                end
                S_WAIT_DATA: begin
                    if (!tmo_zero) tmo_q <= tmo_q - 1'b1;
                    if (bus.stor_data_valid) begin
                        for (int k = 0; k < 8; k++) seq_q[k] <= elem_seq[k];
                        idx_q  <= 3'd0;
                        last_q <= elem_last;
                    end else if (tmo_zero) begin
                        err_q <= 1'b1;
                    end
                end
                S_EMIT: if (bus.tx_ready) begin
                    if (idx_q == last_q) begin
                        if (hdr_q) begin
                            hdr_q <= 1'b0;
                        end else if (!last_elem) begin
                            if (last_col) begin
                                col_q <= 3'd0;
                                row_q <= row_q + 3'd1;
                            end else begin
                                col_q <= col_q + 3'd1;
                            end
                        end
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy                = (state_q != S_IDLE);
    assign done                = (state_q == S_FIN);
    assign err                 = done && err_q;
    assign bus.stor_start_disp = (state_q == S_REQ);
    assign bus.stor_read_en    = (state_q == S_RD);
    assign bus.stor_matrix_id  = id_q;
    assign bus.tx_valid        = (state_q == S_EMIT);
    assign bus.tx_data         = bus.tx_valid ? seq_q[idx_q] : 8'h00;

endmodule
